// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch stage: PC, sync imem read, valid/ready to IR stage
// Optional HALT-opcode stop is compiled in with `define FETCH_HALT_DECODE_EN.
module inst_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [4:0]        HALT_OP  = 5'd31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ir_out,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              halted
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] pc;
  logic              halt_word;  // word currently held in ir_out is a HALT opcode
  logic              halt_hit;   // returning read data is a HALT opcode
  logic              xfer;

  assign xfer = ir_valid & ir_ready;

  // The read strobe and address exist only while in REQ; the address is parked at 0 otherwise.
  assign imem_rd_en = (state == S_REQ);
  assign imem_addr  = (state == S_REQ) ? pc : '0;

`ifdef FETCH_HALT_DECODE_EN
  assign halt_hit = (imem_rdata[31:27] == HALT_OP);
  assign halted   = (state == S_HALT);
`else
  logic unused_halt_op;
  assign unused_halt_op = ^HALT_OP;
  assign halt_hit       = 1'b0;
  assign halted         = 1'b0;
`endif

  // Fetch FSM and the registered word/PC presented to the IR stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      ir_out    <= '0;
      ir_valid  <= 1'b0;
      pc_out    <= '0;
      halt_word <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_REQ;
        end
        S_REQ: begin
          // A redirect here simply re-issues the read at the new target next cycle.
          if (jump_en) begin
            pc    <= jump_addr;
            state <= S_REQ;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (jump_en) begin
            // The returning word belongs to the old path; drop it and leave ir_out untouched.
            pc    <= jump_addr;
            state <= S_REQ;
          end else begin
            ir_out    <= imem_rdata;
            pc_out    <= pc;
            ir_valid  <= 1'b1;
            pc        <= pc + ADDR_W'(1);
            halt_word <= halt_hit;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (jump_en) begin
            // A coinciding transfer has already been consumed; redirect also beats halting.
            pc       <= jump_addr;
            ir_valid <= 1'b0;
            state    <= S_REQ;
          end else if (xfer) begin
            ir_valid <= 1'b0;
            state    <= halt_word ? S_HALT : S_REQ;
          end
        end
        S_HALT: begin
          if (start) begin
            pc    <= RESET_PC;
            state <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - randomized self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, ir_ready, jump_en;
  logic [15:0] jump_addr;
  logic        imem_rd_en, ir_valid, halted;
  logic [15:0] imem_addr, pc_out;
  logic [31:0] imem_rdata, ir_out;

  logic        start4, jump_en4, imem_rd_en4, ir_valid4, halted4;
  logic [3:0]  jump_addr4, imem_addr4, pc_out4;
  logic [31:0] imem_rdata4, ir_out4;

  int          total = 0;
  int          bad   = 0;
  int          xfer_cnt, rd_cnt;
  logic [15:0] exp_pc;
  bit          running, exp_halted;
  logic [31:0] mem [0:65535];

  inst_fetch_unit #(.ADDR_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ir_out(ir_out), .ir_valid(ir_valid), .ir_ready(ir_ready), .pc_out(pc_out),
    .jump_en(jump_en), .jump_addr(jump_addr), .halted(halted)
  );

  inst_fetch_unit #(.ADDR_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .imem_rd_en(imem_rd_en4), .imem_addr(imem_addr4), .imem_rdata(imem_rdata4),
    .ir_out(ir_out4), .ir_valid(ir_valid4), .ir_ready(1'b1), .pc_out(pc_out4),
    .jump_en(jump_en4), .jump_addr(jump_addr4), .halted(halted4)
  );

  // synchronous instruction memories, one-cycle read latency
  always @(posedge clk) if (imem_rd_en) imem_rdata <= mem[imem_addr];
  always @(posedge clk) if (imem_rd_en4) imem_rdata4 <= {28'hC0FFEE0, imem_addr4};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and check against the architectural model:
  // every consumed word must be the next word of the program stream.
  task automatic step(input logic st, input logic rdy, input logic jen, input logic [15:0] ja);
    bit          xfer, stop;
    logic [31:0] w;
    start = st; ir_ready = rdy; jump_en = jen; jump_addr = ja;
    chk("halted", {63'd0, halted}, {63'd0, exp_halted});
    if (imem_rd_en) begin
      rd_cnt++;
      chk("rd_addr", {47'd0, running, imem_addr}, {47'd0, 1'b1, exp_pc});
    end
    xfer = ir_valid && rdy;
    stop = 1'b0;
    if (xfer) begin
      xfer_cnt++;
      w = mem[exp_pc];
      chk("pc_out", {47'd0, running, pc_out}, {47'd0, 1'b1, exp_pc});
      chk("ir_out", {32'd0, ir_out}, {32'd0, w});
      exp_pc = exp_pc + 16'd1;
`ifdef FETCH_HALT_DECODE_EN
      stop = (w[31:27] == 5'd31) && !jen;
`endif
    end
    if (running && jen) exp_pc = ja;
    if (stop) begin
      running = 1'b0; exp_halted = 1'b1;
    end else if (!running && st) begin
      running = 1'b1; exp_pc = 16'd0; exp_halted = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    exp_pc = 16'd0; running = 1'b0; exp_halted = 1'b0;
    xfer_cnt = 0; rd_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; ir_ready = 1'b0; jump_en = 1'b0; jump_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_a", {31'd0, imem_rd_en, imem_addr, pc_out}, 64'd0);
    chk("rst_b", {30'd0, ir_valid, halted, ir_out}, 64'd0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int n;
    int x0;
    logic [3:0] q4 [$];
    start4 = 1'b0; jump_en4 = 1'b0; jump_addr4 = '0;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom & 32'h7FFF_FFFF;
    mem[0] = 32'h1000_0001; mem[1] = 32'h2000_0002; mem[2] = 32'h3000_0003;

    // in-order fetch, latency and read rate
    do_reset();
    step(1, 1, 0, 0); n = 1;
    while (!ir_valid && n < 10) begin step(0, 1, 0, 0); n++; end
    chk("latency", 64'(n), 64'd3);
    xfer_cnt = 0; rd_cnt = 0;
    repeat (9) step(0, 1, 0, 0);
    chk("xfers9", 64'(xfer_cnt), 64'd3);
    chk("reads9", 64'(rd_cnt), 64'd3);

    // backpressure
    do_reset();
    step(1, 0, 0, 0); n = 0;
    while (!ir_valid && n < 10) begin step(0, 0, 0, 0); n++; end
    chk("bp_valid", {63'd0, ir_valid}, 64'd1);
    rd_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ir", {32'd0, ir_out}, 64'h1000_0001);
      chk("bp_pc", {48'd0, pc_out}, 64'd0);
      step(0, 0, 0, 0);
    end
    chk("bp_rd", 64'(rd_cnt), 64'd0);
    step(0, 1, 0, 0);
    chk("bp_next", {47'd0, imem_rd_en, imem_addr}, {47'd0, 1'b1, 16'd1});

    // jump while the read is in flight
    do_reset();
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 16'h0040);
    chk("jw_addr", {47'd0, imem_rd_en, imem_addr}, {47'd0, 1'b1, 16'h0040});
    chk("jw_keep", {32'd0, ir_out}, 64'd0);
    n = 0;
    while (!ir_valid && n < 10) begin step(0, 0, 0, 0); n++; end
    chk("jw_pc", {48'd0, pc_out}, 64'h40);
    chk("jw_ir", {32'd0, ir_out}, {32'd0, mem[16'h0040]});

    // jump coinciding with a transfer in HOLD
    x0 = xfer_cnt;
    step(0, 1, 1, 16'h0080);
    chk("jh_once", 64'(xfer_cnt - x0), 64'd1);
    chk("jh_valid", {63'd0, ir_valid}, 64'd0);
    chk("jh_addr", {47'd0, imem_rd_en, imem_addr}, {47'd0, 1'b1, 16'h0080});
    n = 0;
    while (!ir_valid && n < 10) begin step(0, 0, 0, 0); n++; end
    chk("jh_pc", {48'd0, pc_out}, 64'h80);

    // PC wrap on the 4-bit instance
    start4 = 1'b1; @(negedge clk);
    start4 = 1'b0; jump_en4 = 1'b1; jump_addr4 = 4'd15; @(negedge clk);
    jump_en4 = 1'b0;
    n = 0;
    while (q4.size() < 3 && n < 30) begin
      if (ir_valid4) begin
        q4.push_back(pc_out4);
        chk("w4_ir", {32'd0, ir_out4}, {32'd0, 28'hC0FFEE0, pc_out4});
      end
      @(negedge clk); n++;
    end
    chk("w4_cnt", 64'(q4.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      logic [3:0] e;
      e = 4'd15 + 4'(i);
      chk("w4_pc", {60'd0, (i < q4.size()) ? q4[i] : 4'hX}, {60'd0, e});
    end

`ifdef FETCH_HALT_DECODE_EN
    // halt word at address 2, then restart
    mem[2] = 32'hF800_0000;
    do_reset();
    step(1, 1, 0, 0); n = 0;
    while (!halted && n < 40) begin step(0, 1, 0, 0); n++; end
    chk("halt_hit", {63'd0, halted}, 64'd1);
    chk("halt_xf", 64'(xfer_cnt), 64'd3);
    rd_cnt = 0;
    repeat (5) step(0, 1, 1, 16'h0033);
    chk("halt_rd", 64'(rd_cnt), 64'd0);
    step(1, 1, 0, 0);
    chk("halt_rs", {47'd0, imem_rd_en, imem_addr}, {47'd0, 1'b1, 16'd0});
    // jump beats halt
    do_reset();
    step(1, 0, 0, 0); n = 0;
    while (!(ir_valid && pc_out == 16'd2) && n < 40) begin step(0, 1, 0, 0); n++; end
    step(0, 1, 1, 16'h0010);
    chk("jhalt_h", {63'd0, halted}, 64'd0);
    chk("jhalt_a", {47'd0, imem_rd_en, imem_addr}, {47'd0, 1'b1, 16'h0010});
    mem[2] = 32'h3000_0003;
`endif

    // randomized traffic
    do_reset();
    step(1, 1, 0, 0);
    xfer_cnt = 0;
    for (int i = 0; i < 800; i++)
      step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 16'($urandom));
    chk("rand_xf", {63'd0, xfer_cnt > 50}, 64'd1);

    // asynchronous reset in the middle of WAIT
    do_reset();
    step(1, 1, 0, 0); n = 0;
    while (!ir_valid && n < 10) begin step(0, 1, 0, 0); n++; end
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_a", {31'd0, imem_rd_en, imem_addr, pc_out}, 64'd0);
    chk("arst_b", {30'd0, ir_valid, halted, ir_out}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (4) step(0, 1, 0, 0);
    chk("arst_rd", 64'(rd_cnt), 64'd0);
    chk("arst_v", {63'd0, ir_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the IR/ALU stage.
- Holds the program counter and reads 32-bit words from a synchronous instruction memory (1-cycle read latency).
- Presents each word to the IR stage with a valid/ready handshake; the IR stage latches it and decodes oper_type/rdst/mode/rsrc1/rsrc2/isrc.
- Supports a jump redirect from downstream and an optional halt-opcode stop.

Parameters:
- ADDR_W, 16, PC and instruction-memory address width.
- RESET_PC, 0, PC value after reset and on restart.
- HALT_OP, 5'd31, oper_type value (IR[31:27]) treated as HALT when the optional feature is compiled in.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin fetching; sampled only in IDLE or HALT.
- imem_rd_en  out  1  instruction-memory read strobe.
- imem_addr  out  ADDR_W  instruction-memory address.
- imem_rdata  in  32  read data, valid the cycle after imem_rd_en.
- ir_out  out  32  fetched instruction to the IR stage.
- ir_valid  out  1  ir_out/pc_out valid.
- ir_ready  in  1  IR stage accepts ir_out this cycle.
- pc_out  out  ADDR_W  address of the word on ir_out.
- jump_en  in  1  redirect request, one cycle pulse.
- jump_addr  in  ADDR_W  redirect target.
- halted  out  1  fetch stopped on HALT opcode.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (async, at any time including mid-fetch):
  - state=IDLE, pc=RESET_PC.
  - imem_rd_en=0, imem_addr=0, ir_out=0, ir_valid=0, pc_out=0, halted=0.
  - Any in-flight read is forgotten.
- FSM states: IDLE, REQ, WAIT, HOLD, HALT.
- IDLE: outputs idle. start=1 -> REQ.
- REQ: imem_rd_en=1 and imem_addr=pc, both combinational in this state. Next state is WAIT.
- WAIT: on the clock edge leaving WAIT:
  - ir_out<=imem_rdata, pc_out<=pc, ir_valid<=1, pc<=pc+1 (mod 2^ADDR_W).
  - Next state is HOLD.
- HOLD:
  - ir_valid stays 1; ir_out and pc_out stay stable until transfer.
  - Transfer occurs when ir_valid and ir_ready are both 1. On transfer: ir_valid<=0, next state REQ.
  - Throughput is 1 instruction per 3 cycles with ir_ready tied high.
  - Latency from start to ir_valid=1 is 3 cycles (IDLE->REQ->WAIT->HOLD).
- Jump (jump_en=1 in REQ, WAIT or HOLD):
  - pc<=jump_addr, ir_valid<=0, next state REQ.
  - In WAIT, the returning imem_rdata is discarded and ir_out keeps its old value.
  - In HOLD with a simultaneous transfer, the transfer completes first (the consumer got the word), then the redirect applies.
  - In HOLD without a transfer, the pending word is dropped.
- jump_en is ignored in IDLE and HALT.
- start is ignored in REQ, WAIT and HOLD.
- PC wrap: 2^ADDR_W-1 increments to 0 with no flag.
- ir_ready while ir_valid=0 has no effect.

Optional Feature:
- Macro: FETCH_HALT_DECODE_EN.
- Defined:
  - In WAIT, if imem_rdata[31:27]==HALT_OP, the word is still presented normally (ir_valid=1, HOLD).
  - After its transfer, next state is HALT instead of REQ, and pc holds the address after the HALT word.
  - In HALT: halted=1, no reads issued.
  - start=1 in HALT -> halted<=0, pc<=RESET_PC, next state REQ.
  - A jump coinciding with the HALT word's transfer takes priority: the FSM goes to REQ at jump_addr and does not halt.
- Not defined: halted tied 0, HALT state unreachable, HALT_OP unused.

Test Plan:
- Reset then start, memory words 0x1000_0001,0x2000_0002,0x3000_0003, ir_ready=1 -> three transfers in order with pc_out=0,1,2; first ir_valid exactly 3 cycles after start; imem_rd_en high 1 of every 3 cycles.
- Backpressure: ir_ready=0 for 5 cycles after first ir_valid -> ir_out=0x1000_0001 and pc_out=0 stable, no new imem_rd_en; then ir_ready=1 -> next fetch at addr 1.
- jump_en with jump_addr=0x40 in WAIT -> word from in-flight read never appears; next imem_addr=0x40, next pc_out=0x40.
- jump_en with jump_addr=0x80 in HOLD with ir_ready=1 -> current word transferred once, next fetch at 0x80.
- ADDR_W=4, jump to 15 -> pc_out sequence 15,0,1.
- FETCH_HALT_DECODE_EN defined, word at addr 2 = {5'd31,27'd0} -> transferred, halted=1, no further reads; start -> fetch resumes at RESET_PC. Also assert rst_n=0 mid-WAIT -> all outputs 0 immediately.
